// File: rtl/game_pkg.sv
// game_pkg: state encoding, default limits and the
// raw-input bundle shared by the game flow controller.
package game_pkg;

  localparam int MAX_SCORE_DEF  = 140;
  localparam int HOLD_TICKS_DEF = 64;
  localparam int HOLD_W_DEF     = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_GAME_OVER = 3'd3
  } game_state_t;

  // Bit order matches the rise_detect vector.
  typedef struct packed {
    logic wall;
    logic apple;
    logic pause;
    logic start;
  } btn_t;

endpackage

// File: rtl/game_flow_ctrl_rise_detect.sv
// rise_detect: per-bit rising-edge detector.
// Ports: clk, rst (sync, active-high), cur level in, rise pulse out.
module rise_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cur,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;
  logic         armed;

  // armed stays low for the first cycle after reset so that
  // levels already high coming out of reset are not seen as presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= cur;
      armed <= 1'b1;
    end
  end

  assign rise = cur & ~prev & {W{armed}};

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: play/pause/game-over sequencer for the snake.
// Ports: clk, rst, buttons/tick/collision levels, length in;
//   registered strobes, move_en, state and game_won out.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int MAX_SCORE  = MAX_SCORE_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int HOLD_W     = HOLD_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       tick,
  input  logic       apple_hit,
  input  logic       wall_hit,
  input  logic [7:0] length,
  output logic       good_coll,
  output logic       bad_coll,
  output logic       move_en,
  output logic       score_clr,
  output logic [2:0] state,
  output logic       game_won
);

  localparam logic [7:0] WIN_LEN = 8'(MAX_SCORE);
  localparam logic [7:0] WIN_PRE = 8'(MAX_SCORE - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  btn_t lvl;
  btn_t rise;

  assign lvl = {wall_hit, apple_hit, pause_btn, start_btn};

  rise_detect #(
    .W(4)
  ) u_rise (
    .clk (clk),
    .rst (rst),
    .cur (lvl),
    .rise(rise)
  );

  game_state_t       st_q;
  logic [HOLD_W-1:0] hold_q;
  logic              hold_done;

  assign hold_done = (hold_q == HOLD_MAX);
  assign state     = st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      hold_q    <= '0;
      good_coll <= 1'b0;
      bad_coll  <= 1'b0;
      move_en   <= 1'b0;
      score_clr <= 1'b0;
      game_won  <= 1'b0;
    end else begin
      good_coll <= 1'b0;
      bad_coll  <= 1'b0;
      move_en   <= 1'b0;
      score_clr <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (rise.start) begin
            st_q      <= ST_PLAYING;
            score_clr <= 1'b1;
            game_won  <= 1'b0;
          end
        end
        ST_PLAYING: begin
          move_en <= tick;
          if (rise.wall) begin
            bad_coll <= 1'b1;
            st_q     <= ST_GAME_OVER;
            game_won <= 1'b0;
            hold_q   <= '0;
          end else if (rise.apple) begin
            good_coll <= 1'b1;
            // This apple brings the score to MAX_SCORE.
            if (length >= WIN_PRE) begin
              st_q     <= ST_GAME_OVER;
              game_won <= 1'b1;
              hold_q   <= '0;
            end
          end else if (length >= WIN_LEN) begin
            st_q     <= ST_GAME_OVER;
            game_won <= 1'b1;
            hold_q   <= '0;
          end else if (rise.pause) begin
            st_q <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (rise.pause) begin
            st_q <= ST_PLAYING;
          end
        end
        ST_GAME_OVER: begin
          if (tick && !hold_done) begin
            hold_q <= hold_q + 1'b1;
          end
          // Early presses are dropped, never queued.
          if (rise.start && hold_done) begin
            st_q      <= ST_PLAYING;
            score_clr <= 1'b1;
            game_won  <= 1'b0;
          end
        end
        default: begin
          st_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the snake datapath.
- Owns the play/pause/game-over state machine and edge-detects raw button and collision levels.
- Issues single-cycle good/bad collision strobes to the score tracker and gates movement ticks to the snake mover.
- Enforces a post-game hold-off before a new game may start.

Parameters:
MAX_SCORE, 140, score at which the game ends as a win
HOLD_TICKS, 64, tick strobes to wait in GAME_OVER before start is accepted
HOLD_W, 7, width of hold counter (must satisfy HOLD_W ≥ clog2(HOLD_TICKS+1))

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start_btn  in  1  synchronised start/restart button level
pause_btn  in  1  synchronised pause toggle button level
tick  in  1  one-cycle movement strobe from game timer
apple_hit  in  1  raw good-collision level (head on apple)
wall_hit  in  1  raw bad-collision level (head on wall/body)
length  in  8  current score/length from score tracker
good_coll  out  1  one-cycle strobe to score tracker
bad_coll  out  1  one-cycle strobe to score tracker
move_en  out  1  one-cycle gated tick to snake mover
score_clr  out  1  one-cycle strobe clearing snake body/apple on new game
state  out  3  encoded FSM state for display mux
game_won  out  1  high in GAME_OVER when ended by MAX_SCORE

Behaviour:
- Reset: only the rising edge of clk with rst=1 resets; no asynchronous path.
  - All outputs 0; state=IDLE; hold counter 0; edge-detect history registers 0.
  - rst mid-game returns to IDLE on the next edge regardless of state or inputs.
- Edge detect: prev registers for start_btn, pause_btn, apple_hit, wall_hit. A rise is cur=1 and prev=0. A level held high produces exactly one event.
- All outputs are registered. An event sampled at edge N produces its output during cycle N+1, so latency is 1 clock.
- States, with 3-bit encoding in the package: IDLE=0, PLAYING=1, PAUSED=2, GAME_OVER=3.
  - IDLE:
    - start rise -> PLAYING and pulse score_clr.
    - Collisions and ticks are ignored.
  - PLAYING:
    - move_en = tick.
    - Bad-collision rise:
      - pulse bad_coll.
      - -> GAME_OVER with game_won=0.
    - Good-collision rise (no bad rise in the same cycle):
      - pulse good_coll.
      - If length ≥ MAX_SCORE-1, -> GAME_OVER with game_won=1.
    - Good and bad rise in the same cycle: bad wins. bad_coll pulses, good_coll does not.
    - length ≥ MAX_SCORE without a collision (e.g. tracker preloaded): -> GAME_OVER, game_won=1, no strobe.
    - pause rise (no collision in the same cycle) -> PAUSED. A collision takes priority over pause.
  - PAUSED:
    - move_en=0. Collisions ignored, but their prev registers keep updating so nothing fires on resume.
    - pause rise -> PLAYING.
    - start rise is ignored.
  - GAME_OVER:
    - move_en=0.
    - Hold counter clears on entry and increments on each tick. It saturates at HOLD_TICKS.
    - start rise is accepted only when counter == HOLD_TICKS: -> PLAYING, pulse score_clr, clear game_won.
    - Earlier start rises are discarded and are not queued.
- good_coll, bad_coll, score_clr and move_en never stay high for more than one cycle. good_coll and bad_coll are never high together.
- Hold counter arithmetic is unsigned HOLD_W bits and must never wrap.

Decomposition:
- Package game_pkg:
  - state enum game_state_t (3-bit) with the encodings above.
  - MAX_SCORE default constant.
- One sub-module, rise_detect: a parameterised-width register plus cur & ~prev, with synchronous active-high reset. It is instantiated once, 4 bits wide, for the four raw inputs.
- FSM, hold counter and output registers live in game_flow_ctrl.

Test Plan:
- rst=1 for 2 cycles while all inputs=1 -> all outputs 0, state=0. Release with start_btn still high -> stays IDLE (no rise). Drop then raise start -> state=1 and score_clr=1 for exactly 1 cycle.
- PLAYING: apple_hit held high 10 cycles, 5 ticks -> exactly one good_coll, one cycle after the rise; move_en pulses 5 times, each one cycle after its tick.
- PLAYING: apple_hit and wall_hit rise in the same cycle -> bad_coll=1, good_coll=0, state=3, game_won=0.
- length=139, apple_hit rise -> good_coll pulse, state=3, game_won=1.
- PLAYING: pause rise -> state=2. Ticks give move_en=0. apple_hit rise while paused then held -> no good_coll before or after the second pause rise returns state=1.
- GAME_OVER with HOLD_TICKS=4: start rise after 3 ticks -> ignored. After the 4th tick, start rise -> state=1, score_clr pulse, game_won=0. rst asserted in GAME_OVER -> IDLE next cycle.
